// File: rtl/sapho_seq_pkg.sv
// -----------------------------------------------------------------------------
// sapho_seq_pkg
// Shared definitions for the float-processor program sequencer:
//   - seq_act_e   : the single control action chosen each cycle
//   - prio_enc    : lowest-index-wins priority encoder (up to MAX_NITR sources)
//   - vec_addr    : interrupt vector address for a source index
//   - lvl_width   : width of a stack level counter for a given depth
// -----------------------------------------------------------------------------
package sapho_seq_pkg;

    localparam int unsigned MAX_NITR = 16;
    localparam int unsigned IDX_W    = 4;   // enough to index MAX_NITR sources

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_RET,
        ACT_CAL,
        ACT_JMP,
        ACT_ITR,
        ACT_INC
    } seq_act_e;

    // Occupied-entry counter must reach SDEPTH itself, hence the extra bit.
    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Index 0 is the highest priority; scanning downwards leaves the lowest
    // set index as the final assignment.
    function automatic logic [IDX_W-1:0] prio_enc(input logic [MAX_NITR-1:0] v);
        logic [IDX_W-1:0] k;
        k = '0;
        for (int i = MAX_NITR - 1; i >= 0; i--) begin
            if (v[i]) k = IDX_W'(i);
        end
        return k;
    endfunction

    // Full 32-bit result; the caller truncates to the instruction address width.
    function automatic logic [31:0] vec_addr(input logic [IDX_W-1:0] k,
                                             input int unsigned     base,
                                             input int unsigned     stride);
        return 32'(base + 32'(k) * stride);
    endfunction

endpackage

// File: rtl/ret_stack.sv
// -----------------------------------------------------------------------------
// ret_stack
// Parametrised LIFO holding return addresses. The level counter doubles as
// the write pointer; the top entry is read combinationally.
// A push while full or a pop while empty leaves the stack unchanged; the
// caller is responsible for flagging those events.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset (level only; data not reset)
//   push       in   write push_data on top
//   pop        in   discard the top entry
//   push_data  in   DW-bit entry to push
//   top_data   out  DW-bit current top entry (undefined when empty)
//   lvl        out  occupied entries, 0..SDEPTH
//   full       out  lvl == SDEPTH
//   empty      out  lvl == 0
// -----------------------------------------------------------------------------
module ret_stack import sapho_seq_pkg::*; #(
    parameter int unsigned DW     = 9,
    parameter int unsigned SDEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [DW-1:0]                  push_data,
    output logic [DW-1:0]                  top_data,
    output logic [lvl_width(SDEPTH)-1:0]   lvl,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned AW = $clog2(SDEPTH);
    localparam int unsigned LW = lvl_width(SDEPTH);

    logic [DW-1:0] mem_q [SDEPTH];
    logic [LW-1:0] lvl_q, lvl_d;
    logic [AW-1:0] wr_idx, rd_idx;

    assign full   = (lvl_q == LW'(SDEPTH));
    assign empty  = (lvl_q == '0);
    // Write slot is the level itself; wraps to 0 only when full, when no
    // write happens anyway.
    assign wr_idx = lvl_q[AW-1:0];
    assign rd_idx = wr_idx - AW'(1);

    assign top_data = mem_q[rd_idx];
    assign lvl      = lvl_q;

    always_comb begin
        lvl_d = lvl_q;
        if (push && !full) begin
            lvl_d = lvl_q + LW'(1);
        end else if (pop && !empty) begin
            lvl_d = lvl_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_q <= '0;
        end else begin
            lvl_q <= lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_seq_itr.sv
// -----------------------------------------------------------------------------
// pc_seq_itr
// Program sequencer: PC, subroutine return stack and vectored, prioritised
// interrupt entry for the float processor family.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   hold        in   stall: PC, stack, flags frozen; requests ignored
//   jmp         in   load PC with tgt_addr
//   cal         in   push instr_addr+1, load PC with tgt_addr
//   ret         in   pop stack into PC
//   reti        in   pop stack into PC, clear in_isr
//   tgt_addr    in   MINSTW-bit jump/call target
//   itr_req     in   NITR interrupt request levels (rising edge latched)
//   itr_en      in   global interrupt enable
//   clr_err     in   clear stk_ovf/stk_unf
//   instr_addr  out  registered PC, address issued this cycle
//   flush       out  instruction at instr_addr is discarded (interrupt entry)
//   itr_ack     out  one-hot source being entered this cycle
//   in_isr      out  inside a service routine
//   stk_lvl     out  occupied stack entries
//   stk_ovf     out  sticky: push while full
//   stk_unf     out  sticky: pop while empty
// -----------------------------------------------------------------------------
module pc_seq_itr import sapho_seq_pkg::*; #(
    parameter int unsigned MINSTW  = 9,
    parameter int unsigned SDEPTH  = 8,
    parameter int unsigned NITR    = 4,
    parameter int unsigned ITRBASE = 1,
    parameter int unsigned ITRSTR  = 2,
    parameter int unsigned RSTADD  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hold,
    input  logic                          jmp,
    input  logic                          cal,
    input  logic                          ret,
    input  logic                          reti,
    input  logic [MINSTW-1:0]             tgt_addr,
    input  logic [NITR-1:0]               itr_req,
    input  logic                          itr_en,
    input  logic                          clr_err,
    output logic [MINSTW-1:0]             instr_addr,
    output logic                          flush,
    output logic [NITR-1:0]               itr_ack,
    output logic                          in_isr,
    output logic [lvl_width(SDEPTH)-1:0]  stk_lvl,
    output logic                          stk_ovf,
    output logic                          stk_unf
);

    // Registers
    logic [MINSTW-1:0] pc_q,     pc_d;
    logic [NITR-1:0]   req_q;
    logic [NITR-1:0]   pend_q,   pend_d;
    logic              in_isr_q, in_isr_d;
    logic              ovf_q,    ovf_d;
    logic              unf_q,    unf_d;

    // Stack interface
    logic              stk_push, stk_pop;
    logic [MINSTW-1:0] stk_wdata, stk_top;
    logic              stk_full, stk_empty;

    // Decision signals
    seq_act_e          act;
    logic [MAX_NITR-1:0] pend16;
    logic [IDX_W-1:0]  itr_idx;
    logic [NITR-1:0]   ack_c;
    logic [MINSTW-1:0] pc_inc, pc_vec;

    ret_stack #(
        .DW     (MINSTW),
        .SDEPTH (SDEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (stk_wdata),
        .top_data  (stk_top),
        .lvl       (stk_lvl),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_comb begin
        pend16           = '0;
        pend16[NITR-1:0] = pend_q;
    end

    assign itr_idx = prio_enc(pend16);
    assign pc_inc  = pc_q + MINSTW'(1);   // wraps naturally at 2^MINSTW
    assign pc_vec  = MINSTW'(vec_addr(itr_idx, ITRBASE, ITRSTR));

    // Action select: returns beat calls beat jumps beat interrupt entry.
    // Any control transfer in the same cycle defers interrupt entry.
    always_comb begin
        if (hold) begin
            act = ACT_HOLD;
        end else if (ret || reti) begin
            act = ACT_RET;
        end else if (cal) begin
            act = ACT_CAL;
        end else if (jmp) begin
            act = ACT_JMP;
        end else if (itr_en && !in_isr_q && (|pend_q)) begin
            act = ACT_ITR;
        end else begin
            act = ACT_INC;
        end
    end

    always_comb begin
        pc_d      = pc_inc;
        in_isr_d  = in_isr_q;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_wdata = pc_inc;
        flush     = 1'b0;
        ack_c     = '0;

        case (act)
            ACT_HOLD: begin
                pc_d = pc_q;
            end
            ACT_RET: begin
                stk_pop = 1'b1;
                // Underflow falls through to a plain increment.
                pc_d    = stk_empty ? pc_inc : stk_top;
                if (reti) in_isr_d = 1'b0;
            end
            ACT_CAL: begin
                stk_push  = 1'b1;
                stk_wdata = pc_inc;
                pc_d      = tgt_addr;
            end
            ACT_JMP: begin
                pc_d = tgt_addr;
            end
            ACT_ITR: begin
                // The instruction at pc_q is flushed, so it is the one to
                // resume at after reti.
                stk_push  = 1'b1;
                stk_wdata = pc_q;
                pc_d      = pc_vec;
                in_isr_d  = 1'b1;
                flush     = 1'b1;
                for (int i = 0; i < int'(NITR); i++) begin
                    ack_c[i] = (itr_idx == IDX_W'(i));
                end
            end
            default: begin
                pc_d = pc_inc;
            end
        endcase
    end

    // Sticky error flags: a same-cycle error event overrides clr_err.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (!hold && clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (stk_push && stk_full)  ovf_d = 1'b1;
        if (stk_pop  && stk_empty) unf_d = 1'b1;
    end

    // Edge capture runs even during hold; ack_c is zero while held.
    assign pend_d = (pend_q & ~ack_c) | (itr_req & ~req_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= MINSTW'(RSTADD);
            req_q    <= '0;
            pend_q   <= '0;
            in_isr_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            req_q    <= itr_req;
            pend_q   <= pend_d;
            in_isr_q <= in_isr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign instr_addr = pc_q;
    assign itr_ack    = ack_c;
    assign in_isr     = in_isr_q;
    assign stk_ovf    = ovf_q;
    assign stk_unf    = unf_q;

endmodule

// File: tb/tb_pc_seq_itr.sv
module tb_pc_seq_itr;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold, jmp, cal, ret, reti, itr_en, clr_err;
    logic [8:0]  tgt_addr;
    logic [3:0]  itr_req;
    logic [8:0]  instr_addr;
    logic        flush, in_isr, stk_ovf, stk_unf;
    logic [3:0]  itr_ack;
    logic [3:0]  stk_lvl;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    pc_seq_itr #(
        .MINSTW (9), .SDEPTH (8), .NITR (4),
        .ITRBASE(1), .ITRSTR (2), .RSTADD (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .jmp        (jmp),
        .cal        (cal),
        .ret        (ret),
        .reti       (reti),
        .tgt_addr   (tgt_addr),
        .itr_req    (itr_req),
        .itr_en     (itr_en),
        .clr_err    (clr_err),
        .instr_addr (instr_addr),
        .flush      (flush),
        .itr_ack    (itr_ack),
        .in_isr     (in_isr),
        .stk_lvl    (stk_lvl),
        .stk_ovf    (stk_ovf),
        .stk_unf    (stk_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; hold = 1'b0; jmp = 1'b0; cal = 1'b0; ret = 1'b0; reti = 1'b0;
        itr_en = 1'b0; clr_err = 1'b0; tgt_addr = '0; itr_req = '0;

        // Reset state
        #2;
        chk("rst_addr",  32'(instr_addr), 32'h0);
        chk("rst_flush", 32'(flush),      32'h0);
        chk("rst_ack",   32'(itr_ack),    32'h0);
        chk("rst_isr",   32'(in_isr),     32'h0);
        chk("rst_lvl",   32'(stk_lvl),    32'h0);
        chk("rst_ovf",   32'(stk_ovf),    32'h0);
        chk("rst_unf",   32'(stk_unf),    32'h0);
        #10 rst = 1'b1;   // t=12, between edges
        #1;

        // Free-running increment
        for (int i = 0; i < 5; i++) begin
            chk("inc_addr", 32'(instr_addr), 32'(i));
            tick();
        end
        chk("inc_flush", 32'(flush), 32'h0);

        // Call / return
        jmp = 1'b1; tgt_addr = 9'h010; tick(); jmp = 1'b0;
        chk("jmp_addr", 32'(instr_addr), 32'h010);
        cal = 1'b1; tgt_addr = 9'h080; tick(); cal = 1'b0;
        chk("cal_addr", 32'(instr_addr), 32'h080);
        chk("cal_lvl",  32'(stk_lvl),    32'h1);
        tick(); chk("sub_addr1", 32'(instr_addr), 32'h081);
        tick(); chk("sub_addr2", 32'(instr_addr), 32'h082);
        ret = 1'b1; tick(); ret = 1'b0;
        chk("ret_addr", 32'(instr_addr), 32'h011);
        chk("ret_lvl",  32'(stk_lvl),    32'h0);

        // Two simultaneous sources, serviced in priority order
        jmp = 1'b1; tgt_addr = 9'h01F; tick(); jmp = 1'b0;
        itr_en = 1'b1; itr_req = 4'b1010; tick(); itr_req = 4'b0000; #1;
        chk("itr1_addr",  32'(instr_addr), 32'h020);
        chk("itr1_flush", 32'(flush),      32'h1);
        chk("itr1_ack",   32'(itr_ack),    32'h2);
        tick();
        chk("isr1_addr", 32'(instr_addr), 32'h003);
        chk("isr1_flag", 32'(in_isr),     32'h1);
        chk("isr1_lvl",  32'(stk_lvl),    32'h1);
        chk("nonest_ack", 32'(itr_ack),   32'h0);
        tick(); tick();
        chk("isr1_addr5", 32'(instr_addr), 32'h005);
        reti = 1'b1; tick(); reti = 1'b0; #1;
        chk("reti1_addr", 32'(instr_addr), 32'h020);
        chk("reti1_isr",  32'(in_isr),     32'h0);
        chk("itr2_ack",   32'(itr_ack),    32'h8);
        chk("itr2_flush", 32'(flush),      32'h1);
        tick();
        chk("isr2_addr", 32'(instr_addr), 32'h007);
        reti = 1'b1; tick(); reti = 1'b0; #1;
        chk("reti2_addr", 32'(instr_addr), 32'h020);
        chk("reti2_ack",  32'(itr_ack),    32'h0);

        // Jump in the entry cycle defers the interrupt by one cycle
        itr_req = 4'b0001; tick();
        jmp = 1'b1; tgt_addr = 9'h040; #1;
        chk("defer_flush", 32'(flush),   32'h0);
        chk("defer_ack",   32'(itr_ack), 32'h0);
        tick(); jmp = 1'b0; #1;
        chk("defer_addr",  32'(instr_addr), 32'h040);
        chk("defer_ack2",  32'(itr_ack),    32'h1);
        tick();
        chk("isr3_addr", 32'(instr_addr), 32'h001);
        reti = 1'b1; tick(); reti = 1'b0;
        chk("reti3_addr", 32'(instr_addr), 32'h040);
        itr_req = 4'b0000; itr_en = 1'b0;

        // Overflow: nine calls into an eight-deep stack
        for (int i = 0; i < 9; i++) begin
            cal = 1'b1; tgt_addr = 9'(9'h100 + i); tick();
        end
        cal = 1'b0;
        chk("ovf_addr", 32'(instr_addr), 32'h108);
        chk("ovf_lvl",  32'(stk_lvl),    32'h8);
        chk("ovf_flag", 32'(stk_ovf),    32'h1);
        chk("ovf_unf",  32'(stk_unf),    32'h0);

        // Unwind; the ninth pop underflows
        for (int i = 0; i < 8; i++) begin
            ret = 1'b1; tick();
            chk("pop_addr", 32'(instr_addr), (i == 7) ? 32'h041 : 32'(32'h107 - i));
            chk("pop_lvl",  32'(stk_lvl),    32'(7 - i));
        end
        tick(); ret = 1'b0;
        chk("unf_addr", 32'(instr_addr), 32'h042);
        chk("unf_flag", 32'(stk_unf),    32'h1);
        chk("unf_lvl",  32'(stk_lvl),    32'h0);

        // clr_err loses to a same-cycle error, then clears
        ret = 1'b1; clr_err = 1'b1; tick(); ret = 1'b0;
        chk("clr_race_unf", 32'(stk_unf), 32'h1);
        chk("clr_race_ovf", 32'(stk_ovf), 32'h0);
        tick(); clr_err = 1'b0;
        chk("clr_unf",  32'(stk_unf),    32'h0);
        chk("clr_addr", 32'(instr_addr), 32'h044);

        // Hold freezes PC; edge during hold is still latched
        hold = 1'b1; jmp = 1'b1; tgt_addr = 9'h1AA; itr_en = 1'b1; itr_req = 4'b0100; #1;
        chk("hold_flush", 32'(flush), 32'h0);
        tick();
        chk("hold_addr", 32'(instr_addr), 32'h044);
        chk("hold_ack",  32'(itr_ack),    32'h0);
        hold = 1'b0; jmp = 1'b0; #1;
        chk("unhold_ack",   32'(itr_ack), 32'h4);
        chk("unhold_flush", 32'(flush),   32'h1);
        tick();
        chk("isr4_addr", 32'(instr_addr), 32'h005);
        cal = 1'b1; tgt_addr = 9'h030; tick(); tick(); cal = 1'b0;
        chk("pre_rst_lvl", 32'(stk_lvl), 32'h3);
        chk("pre_rst_isr", 32'(in_isr),  32'h1);

        // Asynchronous reset mid-ISR
        #2 rst = 1'b0; itr_req = 4'b0000; #1;
        chk("arst_addr", 32'(instr_addr), 32'h0);
        chk("arst_isr",  32'(in_isr),     32'h0);
        chk("arst_lvl",  32'(stk_lvl),    32'h0);
        @(negedge clk); rst = 1'b1;
        tick();
        chk("post_rst_addr", 32'(instr_addr), 32'h1);
        chk("post_rst_ack",  32'(itr_ack),    32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
